// File: rtl/foc_cal_sequencer.sv
// ---------------------------------------------------------------------------
// FocCalSequencer (module foc_cal_sequencer)
//
// Per-PWM-period scheduler for the FOC current loop. Each accepted period
// tick waits for a fresh ADC sample, then walks the calculation stages in
// order (clarke, park, PI, anti-park, SVPWM). Each stage gets a one-cycle
// enable, and the sequencer then waits for that stage's valid pulse. Stage
// timeouts and period overruns are flagged. The length of the last
// completed sequence is reported.
//
// Ports:
//   sys_clk              system clock
//   reset_n              asynchronous active-low reset
//   sequencer_enable_in  permits new sequences to start
//   foc_tick_in          one-cycle PWM period start
//   sample_valid_in      current ADC sample ready
//   stage_enable_out     one-hot one-cycle stage enables
//                        (bit0 clarke .. bit4 svpwm)
//   stage_valid_in       stage completion pulses, same bit mapping
//   busy_out             sequence in progress
//   foc_done_out         one-cycle pulse when a sequence completes
//   overrun_err_out      sticky: tick arrived while not idle
//   timeout_err_out      sticky: a stage did not answer in time
//   err_stage_out        index of the stage that timed out
//   err_clear_in         clears error flags, leaves ERROR
//   seq_cycles_out       cycles from tick acceptance to done, last sequence
// ---------------------------------------------------------------------------
module foc_cal_sequencer #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 sys_clk,
   input  logic                 reset_n,
   input  logic                 sequencer_enable_in,
   input  logic                 foc_tick_in,
   input  logic                 sample_valid_in,
   output logic [4:0]           stage_enable_out,
   input  logic [4:0]           stage_valid_in,
   output logic                 busy_out,
   output logic                 foc_done_out,
   output logic                 overrun_err_out,
   output logic                 timeout_err_out,
   output logic [2:0]           err_stage_out,
   input  logic                 err_clear_in,
   output logic [CNT_WIDTH-1:0] seq_cycles_out
);

   typedef enum logic [8:0] {
      IDLE        = 9'b000000001,
      WAIT_SAMPLE = 9'b000000010,
      CLARKE      = 9'b000000100,
      PARK        = 9'b000001000,
      PI          = 9'b000010000,
      ANTI_PARK   = 9'b000100000,
      SVPWM       = 9'b001000000,
      DONE        = 9'b010000000,
      ERROR       = 9'b100000000
   } stateT;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   stateT                r_state;
   stateT                w_nextState;
   logic [7:0]           r_toCnt;
   logic                 w_timeoutHit;
   logic [2:0]           w_stageIdx;
   logic [4:0]           w_stageEnNext;
   logic [CNT_WIDTH-1:0] r_cycleCnt;
   logic [CNT_WIDTH-1:0] w_cycleInc;
   logic                 w_entering;

   logic [4:0]           r_stageEn;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_overrun;
   logic                 r_timeoutErr;
   logic [2:0]           r_errStage;
   logic [CNT_WIDTH-1:0] r_seqCycles;

   assign w_timeoutHit = (r_toCnt == TO_LAST);
   assign w_entering   = (w_nextState != r_state);
   assign w_cycleInc   = (r_cycleCnt == '1) ? r_cycleCnt : r_cycleCnt + 1'b1;

   // State register.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. In a stage state the stage's own valid bit always
   // beats the timeout, so a valid on the last allowed cycle still advances.
   // Valid bits belonging to other stages are ignored.
   always_comb begin
      w_nextState = r_state;
      w_stageIdx  = 3'd0;
      unique case (r_state)
         IDLE: begin
            if (foc_tick_in && sequencer_enable_in) w_nextState = WAIT_SAMPLE;
         end
         WAIT_SAMPLE: begin
            if (sample_valid_in) w_nextState = CLARKE;
         end
         CLARKE: begin
            w_stageIdx = 3'd0;
            if (stage_valid_in[0])  w_nextState = PARK;
            else if (w_timeoutHit)  w_nextState = ERROR;
         end
         PARK: begin
            w_stageIdx = 3'd1;
            if (stage_valid_in[1])  w_nextState = PI;
            else if (w_timeoutHit)  w_nextState = ERROR;
         end
         PI: begin
            w_stageIdx = 3'd2;
            if (stage_valid_in[2])  w_nextState = ANTI_PARK;
            else if (w_timeoutHit)  w_nextState = ERROR;
         end
         ANTI_PARK: begin
            w_stageIdx = 3'd3;
            if (stage_valid_in[3])  w_nextState = SVPWM;
            else if (w_timeoutHit)  w_nextState = ERROR;
         end
         SVPWM: begin
            w_stageIdx = 3'd4;
            if (stage_valid_in[4])  w_nextState = DONE;
            else if (w_timeoutHit)  w_nextState = ERROR;
         end
         DONE: begin
            w_nextState = IDLE;
         end
         ERROR: begin
            if (err_clear_in) w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Stage enables are registered, so they are decoded from the state being
   // entered; the result is high only for the first cycle in that stage.
   always_comb begin
      w_stageEnNext = 5'b00000;
      if (w_entering) begin
         case (w_nextState)
            CLARKE:    w_stageEnNext = 5'b00001;
            PARK:      w_stageEnNext = 5'b00010;
            PI:        w_stageEnNext = 5'b00100;
            ANTI_PARK: w_stageEnNext = 5'b01000;
            SVPWM:     w_stageEnNext = 5'b10000;
            default:   w_stageEnNext = 5'b00000;
         endcase
      end
   end

   // Per-stage timeout counter: zero on the first cycle of every state and
   // counting up while the state is held. It saturates so that a long wait
   // in a state without a timeout cannot wrap around.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_toCnt <= 8'd0;
      end else if (w_entering) begin
         r_toCnt <= 8'd0;
      end else if (r_toCnt != 8'hFF) begin
         r_toCnt <= r_toCnt + 8'd1;
      end
   end

   // Sequence cycle counter. The tick cycle itself is cycle 0, so the
   // counter holds 1 on the first cycle after acceptance. From then on it
   // equals the number of cycles elapsed since the tick, saturating at all
   // ones.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycleCnt <= '0;
      end else if (r_state == IDLE) begin
         if (w_nextState == WAIT_SAMPLE) r_cycleCnt <= CNT_WIDTH'(1);
      end else begin
         r_cycleCnt <= w_cycleInc;
      end
   end

   // Registered status outputs, all decoded from the state being entered so
   // that they line up with the state they describe. seq_cycles_out takes
   // the count that the DONE cycle will have, so it appears together with
   // foc_done_out.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stageEn   <= 5'b00000;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_seqCycles <= '0;
      end else begin
         r_stageEn <= w_stageEnNext;
         r_busy    <= (w_nextState != IDLE) && (w_nextState != ERROR);
         r_done    <= (w_nextState == DONE);
         if ((w_nextState == DONE) && w_entering) r_seqCycles <= w_cycleInc;
      end
   end

   // Error flags. A tick outside IDLE is an overrun, except in ERROR, where
   // ticks are ignored. Leaving ERROR clears everything. Elsewhere a clear
   // only removes the overrun flag, and a simultaneous new overrun wins.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_overrun    <= 1'b0;
         r_timeoutErr <= 1'b0;
         r_errStage   <= 3'd0;
      end else begin
         if (foc_tick_in && (r_state != IDLE) && (r_state != ERROR)) begin
            r_overrun <= 1'b1;
         end else if (err_clear_in) begin
            r_overrun <= 1'b0;
         end

         if ((r_state == ERROR) && err_clear_in) begin
            r_timeoutErr <= 1'b0;
            r_errStage   <= 3'd0;
         end else if ((w_nextState == ERROR) && w_entering) begin
            r_timeoutErr <= 1'b1;
            r_errStage   <= w_stageIdx;
         end
      end
   end

   assign stage_enable_out = r_stageEn;
   assign busy_out         = r_busy;
   assign foc_done_out     = r_done;
   assign overrun_err_out  = r_overrun;
   assign timeout_err_out  = r_timeoutErr;
   assign err_stage_out    = r_errStage;
   assign seq_cycles_out   = r_seqCycles;

endmodule

// File: tb/tb_foc_cal_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for foc_cal_sequencer (TIMEOUT_CYCLES = 8).
// The stimulus side pushes the expected events into a scoreboard queue:
// each stage enable, the done pulse with its cycle count, or the timeout
// error with its stage index, each tagged with the absolute cycle in which
// it must appear. A monitor pops and compares whenever the DUT shows one of
// those events.
// ---------------------------------------------------------------------------
module tb_foc_cal_sequencer;

   localparam int EV_EN    = 1;
   localparam int EV_DONE  = 2;
   localparam int EV_TOERR = 3;

   typedef struct {
      int kind;
      int data;
      int cyc;
   } evT;

   logic        sys_clk;
   logic        reset_n;
   logic        sequencer_enable_in;
   logic        foc_tick_in;
   logic        sample_valid_in;
   logic [4:0]  stage_enable_out;
   logic [4:0]  stage_valid_in;
   logic        busy_out;
   logic        foc_done_out;
   logic        overrun_err_out;
   logic        timeout_err_out;
   logic [2:0]  err_stage_out;
   logic        err_clear_in;
   logic [15:0] seq_cycles_out;

   evT sbQ[$];
   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;
   int latCfg[5];
   logic prevTo;

   foc_cal_sequencer #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) dut (
      .sys_clk             (sys_clk),
      .reset_n             (reset_n),
      .sequencer_enable_in (sequencer_enable_in),
      .foc_tick_in         (foc_tick_in),
      .sample_valid_in     (sample_valid_in),
      .stage_enable_out    (stage_enable_out),
      .stage_valid_in      (stage_valid_in),
      .busy_out            (busy_out),
      .foc_done_out        (foc_done_out),
      .overrun_err_out     (overrun_err_out),
      .timeout_err_out     (timeout_err_out),
      .err_stage_out       (err_stage_out),
      .err_clear_in        (err_clear_in),
      .seq_cycles_out      (seq_cycles_out)
   );

   // 10 ns clock; cyc numbers the current cycle (number of rising edges).
   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual != expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic popCompare(input int kind, input int data);
      evT ev;
      if (sbQ.size() == 0) begin
         nChecks++;
         nFails++;
         $display("[TB] FAIL unexpectedEvent: got kind %0d data %0d, expected none (cycle %0d)",
                  kind, data, cyc);
      end else begin
         ev = sbQ.pop_front();
         checkOutput("eventKind", kind, ev.kind);
         checkOutput("eventData", data, ev.data);
         checkOutput("eventCycle", cyc, ev.cyc);
      end
   endtask

   // Monitor: output events are sampled on the falling edge, away from the
   // edge that updates them.
   always @(negedge sys_clk) begin
      if (!reset_n) begin
         prevTo <= 1'b0;
      end else begin
         if (stage_enable_out != 5'b0) popCompare(EV_EN, int'(stage_enable_out));
         if (foc_done_out) popCompare(EV_DONE, int'(seq_cycles_out));
         if (timeout_err_out && !prevTo) popCompare(EV_TOERR, int'(err_stage_out));
         prevTo <= timeout_err_out;
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic idleInputs();
      sequencer_enable_in = 1'b1;
      foc_tick_in         = 1'b0;
      sample_valid_in     = 1'b0;
      stage_valid_in      = 5'b0;
      err_clear_in        = 1'b0;
   endtask

   // One sequence. The tick is driven in relative cycle 0 and the sample in
   // cycle 1+sampleWait. Stage k's valid comes latCfg[k] cycles after its
   // enable. missStage (>=0) never answers. expEnd is the hand-computed
   // relative cycle of the done pulse (which is also seq_cycles_out) or of
   // the timeout error.
   task automatic applyStimulus(input int sampleWait, input int missStage, input int expEnd,
                                input int extraTickRel, input int dropEnRel, input int strayRel);
      int c0;
      int s;
      int last;
      int e[5];
      logic [4:0] sv;
      evT ev;
      c0   = cyc;
      s    = 1 + sampleWait;
      e[0] = s + 1;
      for (int k = 1; k < 5; k++) e[k] = e[k-1] + latCfg[k-1] + 1;
      last = (missStage >= 0) ? missStage : 4;
      for (int k = 0; k <= last; k++) begin
         ev.kind = EV_EN; ev.data = 1 << k; ev.cyc = c0 + e[k];
         sbQ.push_back(ev);
      end
      ev.kind = (missStage >= 0) ? EV_TOERR : EV_DONE;
      ev.data = (missStage >= 0) ? missStage : expEnd;
      ev.cyc  = c0 + expEnd;
      sbQ.push_back(ev);

      for (int rel = 0; rel <= expEnd; rel++) begin
         foc_tick_in         = (rel == 0) || (rel == extraTickRel);
         sequencer_enable_in = !((dropEnRel >= 0) && (rel >= dropEnRel));
         sample_valid_in     = (rel == s);
         sv = 5'b0;
         for (int k = 0; k <= last; k++)
            if ((k != missStage) && (rel == e[k] + latCfg[k])) sv[k] = 1'b1;
         if (rel == strayRel) sv[1] = 1'b1;
         stage_valid_in = sv;
         step();
         if (rel + 1 == expEnd) begin
            @(negedge sys_clk);
            checkOutput("busyAtEnd", int'(busy_out), (missStage < 0) ? 1 : 0);
         end
      end
      idleInputs();
      @(negedge sys_clk);
      checkOutput("busyAfterEnd", int'(busy_out), 0);
      step();
   endtask

   task automatic setLat(input int l0, input int l1, input int l2, input int l3, input int l4);
      latCfg[0] = l0; latCfg[1] = l1; latCfg[2] = l2; latCfg[3] = l3; latCfg[4] = l4;
   endtask

   // Main stimulus.
   initial begin
      reset_n = 1'b0;
      idleInputs();
      repeat (3) step();
      @(negedge sys_clk);
      checkOutput("rstEnable", int'(stage_enable_out), 0);
      checkOutput("rstBusy", int'(busy_out), 0);
      checkOutput("rstDone", int'(foc_done_out), 0);
      checkOutput("rstErrors", int'({overrun_err_out, timeout_err_out, err_stage_out}), 0);
      checkOutput("rstSeqCycles", int'(seq_cycles_out), 0);
      step();
      reset_n = 1'b1;
      step();

      // Minimum latency: enables in cycles 2..6, done in cycle 7.
      setLat(0, 0, 0, 0, 0);
      applyStimulus(0, -1, 7, -1, -1, -1);

      // Nominal: sample in cycle 4, CLARKE from 5, 4 cycles per stage, done 25.
      setLat(3, 3, 3, 3, 3);
      applyStimulus(3, -1, 25, -1, -1, -1);

      // Timeout in anti-park: enable in cycle 14, ERROR 8 cycles later at 22.
      applyStimulus(0, 3, 22, -1, -1, -1);
      @(negedge sys_clk);
      checkOutput("toErrFlag", int'(timeout_err_out), 1);
      checkOutput("toErrStage", int'(err_stage_out), 3);
      step();
      // Tick together with the clear: back to IDLE, tick dropped.
      foc_tick_in  = 1'b1;
      err_clear_in = 1'b1;
      step();
      idleInputs();
      repeat (3) step();
      @(negedge sys_clk);
      checkOutput("clrToErr", int'(timeout_err_out), 0);
      checkOutput("clrErrStage", int'(err_stage_out), 0);
      checkOutput("clrOverrun", int'(overrun_err_out), 0);
      checkOutput("clrTickDropped", int'(busy_out), 0);
      step();

      // Normal run after recovery: enables 3,4,6,9,13, done 18.
      setLat(0, 1, 2, 3, 4);
      applyStimulus(1, -1, 18, -1, -1, -1);

      // Valid on the timeout cycle (8th cycle of each stage) wins: done 42.
      setLat(7, 7, 7, 7, 7);
      applyStimulus(0, -1, 42, -1, -1, -1);
      @(negedge sys_clk);
      checkOutput("edgeNoTimeout", int'(timeout_err_out), 0);
      step();

      // Overrun: second tick in PI (cycles 8..10); one done at 17.
      setLat(2, 2, 2, 2, 2);
      applyStimulus(0, -1, 17, 9, -1, -1);
      @(negedge sys_clk);
      checkOutput("overrunSet", int'(overrun_err_out), 1);
      step();
      err_clear_in = 1'b1;
      step();
      idleInputs();
      @(negedge sys_clk);
      checkOutput("overrunCleared", int'(overrun_err_out), 0);
      step();

      // Gating: tick with enable low starts nothing.
      sequencer_enable_in = 1'b0;
      foc_tick_in         = 1'b1;
      step();
      idleInputs();
      repeat (3) step();
      @(negedge sys_clk);
      checkOutput("gatedIdle", int'(busy_out), 0);
      step();

      // Enable dropped from cycle 3 on: enables 3,5,7,9,11, done 13.
      setLat(1, 1, 1, 1, 1);
      applyStimulus(1, -1, 13, -1, 3, -1);

      // Stray park valid while in CLARKE (cycles 2..5): enables 2,6,7,8,9, done 10.
      setLat(3, 0, 0, 0, 0);
      applyStimulus(0, -1, 10, -1, -1, 3);

      // Reset during PARK: everything drops at once; a later valid is ignored.
      begin
         evT ev;
         ev.kind = EV_EN; ev.data = 1; ev.cyc = cyc + 2; sbQ.push_back(ev);
         ev.kind = EV_EN; ev.data = 2; ev.cyc = cyc + 3; sbQ.push_back(ev);
      end
      foc_tick_in = 1'b1;
      step();
      foc_tick_in     = 1'b0;
      sample_valid_in = 1'b1;
      step();
      sample_valid_in = 1'b0;
      stage_valid_in  = 5'b00001;
      step();
      stage_valid_in  = 5'b00000;
      @(negedge sys_clk);
      checkOutput("parkBusy", int'(busy_out), 1);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midRstEnable", int'(stage_enable_out), 0);
      checkOutput("midRstBusy", int'(busy_out), 0);
      checkOutput("midRstSeqCycles", int'(seq_cycles_out), 0);
      step();
      reset_n = 1'b1;
      stage_valid_in = 5'b00010;
      step();
      stage_valid_in = 5'b00000;
      repeat (3) step();
      @(negedge sys_clk);
      checkOutput("postRstIdle", int'(busy_out), 0);
      step();

      checkOutput("scoreboardEmpty", sbQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
